// File: rtl/sc_pkg.sv
// Shared constants for the stochastic-computing datapath.
// Widths, window length and generator period; decoder mode states.
package sc_pkg;

  localparam int SC_WIDTH  = 8;
  localparam int SC_WINDOW = 255;
  localparam int SC_PERIOD = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    HOLD  = 2'b10,
    BOTH  = 2'b11
  } sc_mode_t;

endpackage

// File: rtl/sc_window_counter.sv
// Modulo-WINDOW sample counter with enable, sync clear, last flag.
// Ports: clk, rst_n, clr, inc -> idx, last (idx == WINDOW-1).
module sc_window_counter #(
  parameter int WIDTH  = 8,
  parameter int WINDOW = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] idx,
  output logic             last
);

  assign last = (idx == WIDTH'(WINDOW - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc) begin
      idx <= last ? '0 : idx + WIDTH'(1);
    end
  end

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic bitstream to binary: ones count per WINDOW samples.
// Ports: clr/en/bit_valid/bit_in in; result/valid/ready, overrun, busy.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH  = SC_WIDTH,
  parameter int WINDOW = SC_WINDOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             overrun,
  output logic             busy
);

  sc_mode_t         mode;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] ones_nxt;
  logic             last;
  logic             accept;
  logic             done;
  logic             nxt_pend;
  logic             nxt_busy;

  assign accept   = en & bit_valid & ~clr;
  assign done     = accept & last;
  assign ones_nxt = ones + WIDTH'(bit_in);

  sc_window_counter #(
    .WIDTH (WIDTH),
    .WINDOW(WINDOW)
  ) u_win (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (clr),
    .inc  (accept),
    .idx  (idx),
    .last (last)
  );

  assign busy = (idx != '0);

  assign result_valid = (mode == HOLD) ||
                        (mode == BOTH);

  // Pending result: a completion always wins over a transfer.
  always_comb begin
    nxt_pend = result_valid;
    if (clr) begin
      nxt_pend = 1'b0;
    end else if (done) begin
      nxt_pend = 1'b1;
    end else if (result_ready) begin
      nxt_pend = 1'b0;
    end
  end

  // Window occupancy after this edge, mirrors idx != 0.
  always_comb begin
    nxt_busy = busy;
    if (clr) begin
      nxt_busy = 1'b0;
    end else if (accept) begin
      nxt_busy = ~last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= IDLE;
    end else begin
      mode <= sc_mode_t'({nxt_pend, nxt_busy});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones    <= '0;
      result  <= '0;
      overrun <= 1'b0;
    end else begin
      if (clr || done) begin
        ones <= '0;
      end else if (accept) begin
        ones <= ones_nxt;
      end
      if (done) begin
        result <= ones_nxt;
      end
      if (clr) begin
        overrun <= 1'b0;
      end else if (done && result_valid &&
                   !result_ready) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder.
// Hand-computed window counts, handshake, clr and reset cases.
module tb_sc_stream_decoder;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       en;
  logic       bit_valid;
  logic       bit_in;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       overrun;
  logic       busy;

  int errs;
  int total;
  int bad;

  sc_stream_decoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (clr),
    .en          (en),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .result      (result),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input int obs,
                       input int exp);
    total++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d want %0d",
               tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic b);
    en        = 1'b1;
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic idle();
    bit_valid = 1'b0;
    tick();
  endtask

  // First n samples are ones, remaining are zeros.
  task automatic send_run(input int cnt,
                          input int n);
    for (int i = 0; i < cnt; i++) begin
      send(i < n);
    end
  endtask

  initial begin
    errs = 0;
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    clr = 1'b0;
    en = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("rst_result", result, 0);
    check("rst_valid", result_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    send_run(254, 254);
    check("ones_pre_valid", result_valid, 0);
    check("ones_busy", busy, 1);
    send(1'b1);
    check("ones_valid", result_valid, 1);
    check("ones_result", result, 255);
    check("ones_busy_end", busy, 0);
    idle();
    check("ones_pulse", result_valid, 0);

    send_run(255, 0);
    check("zeros_valid", result_valid, 1);
    check("zeros_result", result, 0);
    check("zeros_overrun", overrun, 0);
    idle();
    check("zeros_pulse", result_valid, 0);

    for (int i = 0; i < 255; i++) send(i % 2 == 0);
    check("alt_result", result, 128);
    check("alt_valid", result_valid, 1);
    for (int i = 0; i < 255; i++) send(i % 4 == 0);
    check("quad_result", result, 64);
    check("quad_overrun", overrun, 0);
    idle();

    bad = 0;
    for (int i = 0; i < 255; i++) begin
      if (i == 120) begin
        en = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (busy !== 1'b1) bad++;
        end
        bit_valid = 1'b0;
        en = 1'b1;
      end
      send(i < 100);
      if (i < 254) begin
        if (busy !== 1'b1) bad++;
        idle();
        if (busy !== 1'b1) bad++;
      end
    end
    check("pause_busy_bad", bad, 0);
    check("pause_result", result, 100);
    check("pause_valid", result_valid, 1);
    idle();

    result_ready = 1'b0;
    send_run(255, 50);
    check("ovr1_result", result, 50);
    check("ovr1_overrun", overrun, 0);
    send_run(255, 70);
    check("ovr2_result", result, 70);
    check("ovr2_valid", result_valid, 1);
    check("ovr2_overrun", overrun, 1);
    idle();
    check("ovr_sticky", overrun, 1);
    check("ovr_stable", result, 70);
    clr = 1'b1;
    en = 1'b1;
    bit_valid = 1'b1;
    bit_in = 1'b1;
    tick();
    clr = 1'b0;
    bit_valid = 1'b0;
    check("clr_valid", result_valid, 0);
    check("clr_overrun", overrun, 0);
    check("clr_result", result, 70);
    check("clr_busy", busy, 0);

    send_run(255, 10);
    check("sim_a_result", result, 10);
    send_run(254, 20);
    result_ready = 1'b1;
    send(1'b0);
    check("sim_result", result, 20);
    check("sim_valid", result_valid, 1);
    check("sim_overrun", overrun, 0);
    idle();
    check("sim_drop", result_valid, 0);

    result_ready = 1'b0;
    send_run(100, 40);
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_result", result, 0);
    check("arst_valid", result_valid, 0);
    check("arst_overrun", overrun, 0);
    check("arst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    result_ready = 1'b1;
    tick();
    send_run(255, 30);
    check("fresh_result", result, 30);
    check("fresh_valid", result_valid, 1);
    idle();

    $display("Result: errors=%0d of %0d checks",
             errs, total);
    $finish;
  end

endmodule

// File: doc/sc_stream_decoder.md
Name: sc_stream_decoder

Overview:
- Converts a unipolar stochastic bitstream from a stochastic circuit output back into a binary value.
- Counts ones over a fixed window of WINDOW accepted samples and emits the count as a WIDTH-bit result.
- Uses a valid/ready handshake with sticky overrun detection.
- Sits at the output end of the SC datapath, opposite the LFSR/comparator stream generators; default window matches their 255-state period.

Parameters:
- WIDTH, 8, bit width of the result and internal counters.
- WINDOW, 255, samples per conversion window; legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous restart of the current window; clears the handshake state.
- en  input  1  conversion enable; samples are ignored while low.
- bit_valid  input  1  bit_in carries a sample this cycle.
- bit_in  input  1  stochastic stream bit.
- result  output  WIDTH  ones count of the last completed window.
- result_valid  output  1  result holds an unconsumed value.
- result_ready  input  1  consumer accepts result.
- overrun  output  1  sticky; a completed result was overwritten before it was accepted.
- busy  output  1  current window partially filled (sample index != 0).

Behaviour:
- Reset (rst_n low, asynchronous): sample index, ones count, result, result_valid, overrun and busy all go to 0 immediately. No window may survive reset.
- Sample accepted when en & bit_valid & ~clr.
  - Index increments.
  - Ones count increments by bit_in.
- Window completion: the sample accepted while index == WINDOW-1.
  - Next cycle: result = ones + bit_in (the final sample is included).
  - Ones count and index return to 0.
  - result_valid = 1.
  - Latency from the last sample to result_valid is 1 clock.
- Count arithmetic: unsigned, never exceeds WINDOW, so no saturation logic is needed.
- Handshake:
  - Transfer occurs when result_valid & result_ready.
  - After a transfer with no simultaneous completion, result_valid falls next cycle.
  - result stays stable while result_valid = 1 and no new completion occurs.
- Simultaneous completion and transfer: the new result loads, result_valid stays 1, and overrun does not change.
- Completion while result_valid = 1 and result_ready = 0: result is overwritten with the new count, result_valid stays 1, overrun is set to 1.
- overrun is sticky; only clr or reset clears it.
- clr (synchronous):
  - Index, ones count, result_valid and overrun go to 0 on the next edge.
  - result keeps its value.
  - A sample presented in the same cycle as clr is discarded.
- en low: index and count hold (window paused, not lost). The handshake keeps operating.
- busy = (index != 0), registered-equivalent with no extra latency.
- Internal mode FSM:
  - IDLE (index 0, no pending result).
  - ACCUM (0 < index < WINDOW).
  - HOLD (result_valid set, index 0).
  - ACCUM and HOLD may overlap: accumulation continues while a result is pending, and the block never stalls input.

Decomposition:
- Shared package sc_pkg: SC_WIDTH = 8, SC_WINDOW = 255, and the stream-period constant shared with the generators.
- One sub-module, sc_window_counter: a modulo-WINDOW counter with enable, synchronous clear and a last-sample flag. It is reused by the generator-side control.
- Ones accumulation, result register and handshake stay in the top module.

Test Plan:
- All-ones stream, 255 consecutive valid samples, result_ready = 1 -> result = 255; result_valid high exactly 1 cycle, asserted the cycle after the 255th sample.
- All-zeros stream for one window -> result = 0, result_valid pulses once, overrun = 0.
- Alternating 1,0 starting with 1 for 255 samples -> result = 128. Then a 4th-cycle pattern (1,0,0,0) for the next window -> result = 64.
- bit_valid high every other cycle, 255 valid samples of which 100 are ones, en toggled low for 20 cycles mid-window -> result = 100. busy stays high throughout the window, including while paused.
- result_ready = 0 across two full windows (first 50 ones, second 70 ones) -> after the second, result = 70, result_valid = 1, overrun = 1. Then one cycle of clr -> result_valid = 0, overrun = 0, result still 70.
- rst_n pulled low at sample 100 of a window -> all outputs 0 asynchronously. After release, a fresh 255-sample window of 30 ones -> result = 30.
